uart_rx_fifo: RTL

Second-generation UART receiver with a generic oversampling factor and an integrated receive FIFO.
- Frames 5-9 data bits with none/odd/even parity and 1 or 2 stop bits, all checked.
- Detects line break; tags each received word with per-word error flags.
- Sits between the pad synchroniser and the bus-side register interface, replacing the single-word RX holding register.

---
 rtl/uart_rx_fifo.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver with oversampled majority-vote bit recovery, break detection and a show-ahead RX FIFO.
// States: IDLE wait start edge | START check start bit | DATA shift bits | PARITY check | STOP check/push | BRK_WAIT wait line high
module uart_rx_fifo #(
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rx_en_i,
  input  logic [1:0]                  parity_i,
  input  logic [2:0]                  data_bits_i,
  input  logic                        stop_bits_i,
  input  logic [DIV_W-1:0]            baud_div_i,
  input  logic                        rx_i,
  input  logic                        rd_en_i,
  output logic [11:0]                 rd_data_o,
  output logic                        rd_valid_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
  output logic                        overrun_o,
  input  logic                        overrun_clr_i,
  output logic                        break_det_o,
  output logic                        rx_idle_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] S_FIRST = SW'(OVERSAMPLE/2 - 1);
  localparam logic [SW-1:0] S_LAST  = SW'(OVERSAMPLE/2 + 1);
  localparam logic [SW-1:0] S_RES   = SW'(OVERSAMPLE/2 + 2);
  localparam logic [SW-1:0] S_END   = SW'(OVERSAMPLE - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_e;

  state_e            state_q, state_d;
  logic              sync1_q, sync2_q, dly_q, line, fall, start_edge;
  logic [DIV_W-1:0]  tcnt_q, div_m1;
  logic              tick, resolve, bit_v;
  logic [SW-1:0]     samp_q;
  logic [2:0]        smp_q;
  logic [3:0]        nbits_q, bit_cnt_q;
  logic              par_en_q, par_odd_q, two_stop_q, stop_cnt_q;
  logic [8:0]        data_q;
  logic              par_acc_q, perr_q, ferr_q, zero_q;
  logic              push, brk, last_data;
  logic [11:0]       push_data;

  // Line is forced idle while disabled so a frame in flight runs out on 1s.
  assign line = sync2_q | ~rx_en_i;
  assign fall = dly_q & ~line;
  assign start_edge = (state_q == IDLE) && fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      dly_q   <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      dly_q   <= line;
    end
  end

  assign div_m1 = (baud_div_i == '0) ? '0 : baud_div_i - 1'b1;
  assign tick   = (tcnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q <= '0;
      samp_q <= '0;
      smp_q  <= '0;
    end else begin
      if (start_edge || tick) tcnt_q <= div_m1;
      else                    tcnt_q <= tcnt_q - 1'b1;
      if (state_q == IDLE) samp_q <= '0;
      else if (tick)       samp_q <= (samp_q == S_END) ? '0 : samp_q + 1'b1;
      if (tick && state_q != IDLE && samp_q >= S_FIRST && samp_q <= S_LAST)
        smp_q <= {smp_q[1:0], line};
    end
  end

  assign bit_v   = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
  assign resolve = tick && (state_q != IDLE) && (samp_q == S_RES);
  assign last_data = (bit_cnt_q == nbits_q - 4'd1);

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    brk     = 1'b0;
    case (state_q)
      IDLE:     if (fall) state_d = START;
      START:    if (resolve) state_d = bit_v ? IDLE : DATA;
      DATA:     if (resolve && last_data) state_d = par_en_q ? PARITY : STOP;
      PARITY:   if (resolve) state_d = STOP;
      STOP: begin
        if (resolve && (stop_cnt_q || !two_stop_q)) begin
          push    = 1'b1;
          brk     = zero_q & ~bit_v;
          state_d = brk ? BRK_WAIT : IDLE;
        end
      end
      BRK_WAIT: if (line) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nbits_q    <= 4'd8;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      data_q     <= '0;
      par_acc_q  <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      zero_q     <= 1'b1;
    end else if (start_edge) begin
      nbits_q    <= (data_bits_i > 3'd4) ? 4'd8 : 4'(data_bits_i) + 4'd5;
      par_en_q   <= (parity_i == 2'b01) || (parity_i == 2'b10);
      par_odd_q  <= (parity_i == 2'b01);
      two_stop_q <= stop_bits_i;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      data_q     <= '0;
      par_acc_q  <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      zero_q     <= 1'b1;
    end else if (resolve) begin
      case (state_q)
        DATA: begin
          data_q[bit_cnt_q] <= bit_v;
          bit_cnt_q         <= bit_cnt_q + 4'd1;
          par_acc_q         <= par_acc_q ^ bit_v;
          if (bit_v) zero_q <= 1'b0;
        end
        PARITY: begin
          perr_q <= bit_v != (par_acc_q ^ par_odd_q);
          if (bit_v) zero_q <= 1'b0;
        end
        STOP: begin
          stop_cnt_q <= 1'b1;
          if (!bit_v) ferr_q <= 1'b1;
          else        zero_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // The final stop bit is folded in combinationally so the push lands in its resolve cycle.
  assign push_data   = brk ? 12'hC00 : {1'b0, ferr_q | ~bit_v, perr_q, data_q};
  assign break_det_o = brk;
  assign rx_idle_o   = (state_q == IDLE);

  logic [11:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          pop, full, wr, ovr_q;

  assign full = (cnt_q == FULL_CNT);
  assign pop  = rd_en_i && (cnt_q != '0);
  assign wr   = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovr_q    <= 1'b0;
    end else begin
      if (wr)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (push && full && !pop) ovr_q <= 1'b1;
      else if (overrun_clr_i)   ovr_q <= 1'b0;
    end
  end

  assign rd_valid_o   = (cnt_q != '0);
  assign rd_data_o    = rd_valid_o ? mem_q[rd_ptr_q] : 12'h000;
  assign fifo_count_o = cnt_q;
  assign overrun_o    = ovr_q;

endmodule
